uart_fifo: RTL and testbench

- Next-generation UART for the CPU peripheral bus. Adds runtime baud divisor, selectable data width and parity, and per-byte error reporting.
- Adds TX and RX FIFOs so software can burst writes and tolerate read latency.
- Sits between the I/O register decoder and the board pins.
- 1 start bit, 1 stop bit, LSB first.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 47 ++++
 rtl/uart_fifo.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the buffered UART.
package uart_pkg;

    localparam int MIN_DIV = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } par_mode_t;

    // Parity bit to transmit / expect; data is zero-extended so narrow frames work.
    // Mode 3 behaves like PAR_NONE.
    function automatic logic par_bit(input logic [7:0] data, input logic [1:0] mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; one extra wrap bit distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_fifo.sv
// Buffered UART: TX/RX FIFOs, runtime divisor, optional parity, per-byte
// parity/framing flags and a sticky RX overrun indication.
//
// state  | meaning
// IDLE   | line idle, timer held at 0
// START  | start bit (RX: confirm at half bit)
// DATA   | DATA_BITS data bits, LSB first
// PARITY | parity bit, only when parity is enabled
// STOP   | stop bit (RX: sampled mid-bit then back to IDLE)
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [1:0]           par_mode,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 wr,
    output logic                 tx_ready,
    output logic                 tx_idle,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rd,
    output logic                 overrun,
    input  logic                 clr_ovr
);

    localparam logic [3:0]           LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN  = DIV_WIDTH'(MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] div_eff;
    assign div_eff = (div < DIV_MIN) ? DIV_MIN : div;

    // ---------------- TX ----------------
    uart_state_t          tx_state, tx_state_n;
    logic                 tx_push, tx_pop, tx_full, tx_empty, tx_load, tx_full_evt, tx_q;
    logic [DATA_BITS-1:0] tx_head, tx_shift, tx_byte;
    logic [DIV_WIDTH-1:0] tx_div_l, tx_timer;
    logic [1:0]           tx_par_l;
    logic [3:0]           tx_bits;

    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign tx_ready    = ~tx_full | tx_pop;
    assign tx_push     = wr & tx_ready;
    assign tx_pop      = tx_load;
    assign tx_full_evt = (tx_timer == tx_div_l - ONE);
    assign tx_idle     = tx_empty && (tx_state == IDLE);
    assign tx          = tx_q;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (tx_data),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // TX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= IDLE;
        else     tx_state <= tx_state_n;
    end

    // TX next state; tx_load pops the FIFO and starts a frame.
    always_comb begin
        tx_state_n = tx_state;
        tx_load    = 1'b0;
        case (tx_state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_load    = 1'b1;
                    tx_state_n = START;
                end
            end
            START:  if (tx_full_evt) tx_state_n = DATA;
            DATA: begin
                if (tx_full_evt && tx_bits == LAST_BIT)
                    tx_state_n = par_enabled(tx_par_l) ? PARITY : STOP;
            end
            PARITY: if (tx_full_evt) tx_state_n = STOP;
            STOP: begin
                if (tx_full_evt) begin
                    if (!tx_empty) begin
                        tx_load    = 1'b1;
                        tx_state_n = START;
                    end else begin
                        tx_state_n = IDLE;
                    end
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    // TX datapath: bit timer, shift register and registered line driver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_timer <= '0;
            tx_div_l <= DIV_MIN;
            tx_par_l <= 2'd0;
            tx_shift <= '0;
            tx_byte  <= '0;
            tx_bits  <= '0;
            tx_q     <= 1'b1;
        end else begin
            if (tx_state == IDLE || tx_full_evt) tx_timer <= '0;
            else                                 tx_timer <= tx_timer + ONE;
            if (tx_load) begin
                tx_div_l <= div_eff;
                tx_par_l <= par_mode;
                tx_shift <= tx_head;
                tx_byte  <= tx_head;
                tx_bits  <= '0;
            end else if (tx_state == DATA && tx_full_evt) begin
                tx_shift <= tx_shift >> 1;
                tx_bits  <= tx_bits + 4'd1;
            end
            case (tx_state)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= tx_shift[0];
                PARITY:  tx_q <= par_bit(8'(tx_byte), tx_par_l);
                default: tx_q <= 1'b1;
            endcase
        end
    end

    // ---------------- RX ----------------
    uart_state_t          rx_state, rx_state_n;
    logic                 rx_s1, rx_s2, rx_filt;
    logic [3:0]           rx_samp;
    logic [DIV_WIDTH-1:0] rx_div_l, rx_timer;
    logic [1:0]           rx_par_l;
    logic [DATA_BITS-1:0] rx_shift;
    logic [3:0]           rx_bits;
    logic                 rx_perr_q, rx_begin, rx_restart, rx_push;
    logic                 rx_full_evt, rx_half_evt, rx_full, rx_empty;
    logic [DATA_BITS+1:0] rx_din, rx_dout;

    assign rx_full_evt = (rx_timer == rx_div_l - ONE);
    assign rx_half_evt = (rx_timer == (rx_div_l >> 1) - ONE);
    assign rx_din      = {rx_shift, rx_perr_q, ~rx_filt};

    sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rd),
        .din   (rx_din),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_valid = ~rx_empty;
    assign {rx_data, rx_perr, rx_ferr} = rx_empty ? '0 : rx_dout;

    // Synchroniser plus 4-sample glitch filter; the filter only moves on unanimity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_samp <= 4'hF;
            rx_filt <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_samp <= {rx_samp[2:0], rx_s2};
            if (rx_samp == 4'hF)      rx_filt <= 1'b1;
            else if (rx_samp == 4'h0) rx_filt <= 1'b0;
        end
    end

    // RX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= IDLE;
        else     rx_state <= rx_state_n;
    end

    // RX next state; the timer restarts at mid-start so later full events land mid-bit.
    always_comb begin
        rx_state_n = rx_state;
        rx_begin   = 1'b0;
        rx_restart = 1'b0;
        rx_push    = 1'b0;
        case (rx_state)
            IDLE: begin
                if (!rx_filt) begin
                    rx_begin   = 1'b1;
                    rx_state_n = START;
                end
            end
            START: begin
                if (rx_half_evt) begin
                    if (!rx_filt) begin
                        rx_restart = 1'b1;
                        rx_state_n = DATA;
                    end else begin
                        rx_state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (rx_full_evt && rx_bits == LAST_BIT)
                    rx_state_n = par_enabled(rx_par_l) ? PARITY : STOP;
            end
            PARITY: if (rx_full_evt) rx_state_n = STOP;
            STOP: begin
                if (rx_full_evt) begin
                    rx_push    = 1'b1;
                    rx_state_n = IDLE;
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    // RX datapath: bit timer, deserialiser, parity check and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_timer  <= '0;
            rx_div_l  <= DIV_MIN;
            rx_par_l  <= 2'd0;
            rx_shift  <= '0;
            rx_bits   <= '0;
            rx_perr_q <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rx_state == IDLE || rx_restart || rx_full_evt) rx_timer <= '0;
            else                                               rx_timer <= rx_timer + ONE;
            if (rx_begin) begin
                rx_div_l  <= div_eff;
                rx_par_l  <= par_mode;
                rx_bits   <= '0;
                rx_perr_q <= 1'b0;
            end else if (rx_state == DATA && rx_full_evt) begin
                rx_shift <= {rx_filt, rx_shift[DATA_BITS-1:1]};
                rx_bits  <= rx_bits + 4'd1;
            end else if (rx_state == PARITY && rx_full_evt) begin
                rx_perr_q <= rx_filt ^ par_bit(8'(rx_shift), rx_par_l);
            end
            if (rx_push && rx_full && !rd) overrun <= 1'b1;
            else if (clr_ovr)              overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: loopback, parity/framing errors, overrun,
// back-to-back TX framing, glitch rejection and asynchronous reset.
module tb_uart_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_pin, tx;
    logic [15:0] div;
    logic [1:0]  par_mode;
    logic [7:0]  tx_data;
    logic        wr, tx_ready, tx_idle;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_valid, rd, overrun, clr_ovr;
    logic        loopback, rx_drv;
    int          n_checks = 0;
    int          n_fail = 0;

    assign rx_pin = loopback ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx_pin),
        .tx       (tx),
        .div      (div),
        .par_mode (par_mode),
        .tx_data  (tx_data),
        .wr       (wr),
        .tx_ready (tx_ready),
        .tx_idle  (tx_idle),
        .rx_data  (rx_data),
        .rx_perr  (rx_perr),
        .rx_ferr  (rx_ferr),
        .rx_valid (rx_valid),
        .rd       (rd),
        .overrun  (overrun),
        .clr_ovr  (clr_ovr)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int per);
        rx_drv = b;
        tick(per);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par, input logic pb,
                              input logic stopb, input int per);
        send_bit(1'b0, per);
        for (int i = 0; i < 8; i++) send_bit(d[i], per);
        if (use_par) send_bit(pb, per);
        send_bit(stopb, per);
    endtask

    task automatic wait_valid(input string tag, input int bound);
        for (int k = 0; k < bound && !rx_valid; k++) tick(1);
        check(tag, 16'(rx_valid), 16'd1);
    endtask

    task automatic pop_rx();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    logic [7:0] burst [4];
    logic [7:0] d;
    logic       want;

    initial begin
        rst = 1'b1; rx_drv = 1'b1; loopback = 1'b0; div = 16'd8; par_mode = 2'd0;
        tx_data = 8'h00; wr = 1'b0; rd = 1'b0; clr_ovr = 1'b0;
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
        tick(3);
        check("rst_tx", 16'(tx), 16'd1);
        check("rst_tx_ready", 16'(tx_ready), 16'd1);
        check("rst_tx_idle", 16'(tx_idle), 16'd1);
        check("rst_rx_valid", 16'(rx_valid), 16'd0);
        check("rst_rx_data", 16'(rx_data), 16'd0);
        check("rst_rx_perr", 16'(rx_perr), 16'd0);
        check("rst_rx_ferr", 16'(rx_ferr), 16'd0);
        check("rst_overrun", 16'(overrun), 16'd0);
        @(negedge clk) rst = 1'b0;
        tick(2);

        // 1: loopback 0xA5, tx goes low two edges after the write edge
        loopback = 1'b1;
        tx_data = 8'hA5; wr = 1'b1;
        tick(1);
        wr = 1'b0;
        check("t1_tx_edge0", 16'(tx), 16'd1);
        tick(1);
        check("t1_tx_edge1", 16'(tx), 16'd1);
        tick(1);
        check("t1_tx_edge2", 16'(tx), 16'd0);
        check("t1_tx_idle_busy", 16'(tx_idle), 16'd0);
        wait_valid("t1_valid", 300);
        check("t1_data", 16'(rx_data), 16'h00A5);
        check("t1_perr", 16'(rx_perr), 16'd0);
        check("t1_ferr", 16'(rx_ferr), 16'd0);
        pop_rx();
        check("t1_empty", 16'(rx_valid), 16'd0);
        tick(20);
        loopback = 1'b0;
        check("t1_tx_idle_done", 16'(tx_idle), 16'd1);

        // 2: even parity; 0x03 expects parity 0
        par_mode = 2'd1;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 8);
        send_bit(1'b1, 16);
        wait_valid("t2a_valid", 100);
        check("t2a_data", 16'(rx_data), 16'h0003);
        check("t2a_perr", 16'(rx_perr), 16'd1);
        check("t2a_ferr", 16'(rx_ferr), 16'd0);
        pop_rx();
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 8);
        send_bit(1'b1, 16);
        wait_valid("t2b_valid", 100);
        check("t2b_data", 16'(rx_data), 16'h0003);
        check("t2b_perr", 16'(rx_perr), 16'd0);
        pop_rx();

        // 3: framing error, then drain anything the low stop bit triggered
        par_mode = 2'd0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 8);
        send_bit(1'b1, 96);
        wait_valid("t3a_valid", 100);
        check("t3a_data", 16'(rx_data), 16'h0055);
        check("t3a_ferr", 16'(rx_ferr), 16'd1);
        check("t3a_perr", 16'(rx_perr), 16'd0);
        for (int k = 0; k < 4 && rx_valid; k++) pop_rx();
        check("t3_drained", 16'(rx_valid), 16'd0);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 8);
        send_bit(1'b1, 16);
        wait_valid("t3b_valid", 100);
        check("t3b_data", 16'(rx_data), 16'h0012);
        check("t3b_perr", 16'(rx_perr), 16'd0);
        check("t3b_ferr", 16'(rx_ferr), 16'd0);
        pop_rx();

        // 4: 17 bytes without reads overflow a 16-deep FIFO
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1, 8);
        check("t4_no_ovr_yet", 16'(overrun), 16'd0);
        send_frame(8'h10, 1'b0, 1'b0, 1'b1, 8);
        send_bit(1'b1, 16);
        check("t4_overrun", 16'(overrun), 16'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_read%0d", i), 16'(rx_data), 16'(i));
            pop_rx();
        end
        check("t4_empty", 16'(rx_valid), 16'd0);
        check("t4_ovr_sticky", 16'(overrun), 16'd1);
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        check("t4_ovr_clr", 16'(overrun), 16'd0);

        // 5: burst of 4 odd-parity frames at div=10, sampled mid-bit
        div = 16'd10; par_mode = 2'd2;
        for (int i = 0; i < 4; i++) begin
            tx_data = burst[i]; wr = 1'b1;
            tick(1);
        end
        wr = 1'b0;
        check("t5_tx_idle_busy", 16'(tx_idle), 16'd0);
        tick(4);
        for (int f = 0; f < 4; f++) begin
            d = burst[f];
            for (int b = 0; b < 11; b++) begin
                if (b == 0)      want = 1'b0;
                else if (b < 9)  want = d[b-1];
                else if (b == 9) want = ~^d;
                else             want = 1'b1;
                check($sformatf("t5_f%0d_b%0d", f, b), 16'(tx), 16'(want));
                if (!(f == 3 && b == 10)) tick(10);
            end
        end
        tick(10);
        check("t5_tx_idle_end", 16'(tx_idle), 16'd1);
        check("t5_tx_end", 16'(tx), 16'd1);

        // 6: glitch rejection, then async reset mid-frame in both directions
        div = 16'd8; par_mode = 2'd0;
        rx_drv = 1'b0;
        tick(2);
        rx_drv = 1'b1;
        tick(150);
        check("t6_glitch", 16'(rx_valid), 16'd0);
        tx_data = 8'h00; wr = 1'b1;
        tick(1);
        wr = 1'b0;
        rx_drv = 1'b0;
        tick(40);
        check("t6_tx_midframe", 16'(tx), 16'd0);
        check("t6_tx_busy", 16'(tx_idle), 16'd0);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_tx", 16'(tx), 16'd1);
        check("t6_rst_rx_valid", 16'(rx_valid), 16'd0);
        check("t6_rst_tx_ready", 16'(tx_ready), 16'd1);
        check("t6_rst_tx_idle", 16'(tx_idle), 16'd1);
        @(negedge clk);
        rst = 1'b0;
        rx_drv = 1'b1;
        tick(200);
        check("t6_post_rx_valid", 16'(rx_valid), 16'd0);
        check("t6_post_tx", 16'(tx), 16'd1);
        check("t6_post_tx_idle", 16'(tx_idle), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
